pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of the read-data, ALU-result and write-back data paths.
REQ-002 Parameter RA_W, default 3, SHALL set the width of the destination-register address.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  in  1  SHALL mean the upstream beat is valid.
REQ-006 in_ready  out  1  SHALL mean the block accepts a beat this cycle.
REQ-007 flush  in  1  SHALL mean discard all held and incoming beats.
REQ-008 memToReg_i, regWrite_i  in  1 each  SHALL be the write-back control for the incoming beat.
REQ-009 readData_i, aluRes_i  in  DATA_W each  SHALL be the memory read data and the ALU result.
REQ-010 rd_i  in  RA_W  SHALL be the destination register address.
REQ-011 out_valid  out  1  SHALL mean the output beat is valid.
REQ-012 out_ready  in  1  SHALL mean downstream consumes the output beat this cycle.
REQ-013 memToReg_o  out  1, readData_o/aluRes_o  out  DATA_W, rd_o  out  RA_W  SHALL be the held output beat.
REQ-014 regWrite_o  out  1  SHALL be the held regWrite AND out_valid.
REQ-015 wbData_o  out  DATA_W  SHALL be the combinational select readData_o if memToReg_o=1, else aluRes_o.
REQ-016 occupancy  out  2  SHALL be the number of held beats (0..2).

Function
REQ-017 Storage SHALL be one main register driving the outputs plus one skid register, each with a valid bit and a full payload (memToReg, regWrite, readData, aluRes, rd).
REQ-018 in_ready SHALL equal NOT skid_valid, taken from the registered state only, with no combinational path from out_ready.
REQ-019 An accept SHALL occur when in_valid=1 and in_ready=1; a consume SHALL occur when out_valid=1 and out_ready=1.
REQ-020 If main is empty or consumed and skid is valid, main SHALL load from skid and skid SHALL empty.
REQ-021 If main is empty or consumed, skid is empty and an accept occurs, main SHALL load the input beat.
REQ-022 If main is valid and not consumed and an accept occurs, skid SHALL load the input beat.
REQ-023 If main is consumed with no accept and skid empty, out_valid SHALL go 0 next cycle.
REQ-024 Latency SHALL be 1 cycle from accept to out_valid when the block is empty.
REQ-025 Beat order SHALL be preserved, with no beat dropped or duplicated absent flush.
REQ-026 With out_ready held 1, throughput SHALL be one beat per cycle.
REQ-027 While out_ready=0, output payload SHALL hold stable.
REQ-028 flush=1 SHALL clear both valid bits at the next edge, and an input beat in the same cycle SHALL be discarded.
REQ-029 flush SHALL take priority over accept, consume and skid transfer.
REQ-030 Payload registers MAY retain stale data while invalid; regWrite_o SHALL be 0 whenever out_valid=0.
REQ-031 occupancy SHALL equal main_valid + skid_valid.

Reset
REQ-032 rst=0 SHALL immediately, without waiting for clk, clear all valid bits and payload registers to 0.
REQ-033 During and after reset: out_valid=0, regWrite_o=0, memToReg_o=0, readData_o=aluRes_o=wbData_o=0, rd_o=0, occupancy=0, in_ready=1.
REQ-034 Reset asserted mid-transfer SHALL discard all held beats; the first accept after release SHALL behave as into an empty block.

Verification
REQ-035 Reset release, single beat (readData=8'hA5, aluRes=8'h3C, memToReg=1, regWrite=1, rd=5), out_ready=1 -> next cycle out_valid=1, wbData_o=8'hA5, rd_o=5, regWrite_o=1; following cycle out_valid=0.
REQ-036 Streaming 10 beats (aluRes=0..9, memToReg=0), in_valid and out_ready held 1 -> wbData_o outputs 0..9 on consecutive cycles, in_ready stays 1, occupancy stays 1.
REQ-037 out_ready=0, three beats offered back-to-back -> first two accepted, occupancy=2, in_ready=0 on the third, payload stable; out_ready=1 -> beats emerge in order, in_ready returns 1 after the skid empties.
REQ-038 occupancy=2 plus flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, regWrite_o=0, incoming beat never appears.
REQ-039 rst=0 pulsed between clock edges while occupancy=2 -> outputs zero immediately, in_ready=1; a subsequent beat appears with 1-cycle latency.
REQ-040 Random in_valid/out_ready/flush, 10k cycles, scoreboard -> ordering, no loss or duplication outside flush, regWrite_o never 1 with out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : MEM/WB pipeline register with a one-entry skid buffer
// Revision 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              memToReg_i,
  input  logic              regWrite_i,
  input  logic [DATA_W-1:0] readData_i,
  input  logic [DATA_W-1:0] aluRes_i,
  input  logic [RA_W-1:0]   rd_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              memToReg_o,
  output logic              regWrite_o,
  output logic [DATA_W-1:0] readData_o,
  output logic [DATA_W-1:0] aluRes_o,
  output logic [RA_W-1:0]   rd_o,
  output logic [DATA_W-1:0] wbData_o,
  output logic [1:0]        occupancy
);

  // Payload layout: {memToReg, regWrite, readData, aluRes, rd}
  localparam int PW = 2 + 2 * DATA_W + RA_W;

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;

  logic          w_accept;
  logic          w_main_free;
  logic [PW-1:0] w_in_beat;

  assign w_in_beat   = {memToReg_i, regWrite_i, readData_i, aluRes_i, rd_i};
  assign in_ready    = ~skid_valid_q;
  assign w_accept    = in_valid & in_ready;
  // Main can take a new beat when it is empty or being consumed this cycle.
  assign w_main_free = ~main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_main_free) begin
      if (skid_valid_q) begin
        // Skid holds the older beat; in_ready is low so no accept competes.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        main_d       = w_in_beat;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_d       = w_in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  logic w_main_rw;

  assign {memToReg_o, w_main_rw, readData_o, aluRes_o, rd_o} = main_q;
  assign out_valid  = main_valid_q;
  assign regWrite_o = w_main_rw & main_valid_q;
  assign wbData_o   = memToReg_o ? readData_o : aluRes_o;
  assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// tb_pipe_stage_reg : directed + randomized bench against a FIFO-queue model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  localparam int DW = 8;
  localparam int AW = 3;

  typedef struct packed {
    logic          m;
    logic          w;
    logic [DW-1:0] rdat;
    logic [DW-1:0] alu;
    logic [AW-1:0] rd;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          memToReg_i = 1'b0;
  logic          regWrite_i = 1'b0;
  logic [DW-1:0] readData_i = '0;
  logic [DW-1:0] aluRes_i = '0;
  logic [AW-1:0] rd_i = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          memToReg_o;
  logic          regWrite_o;
  logic [DW-1:0] readData_o;
  logic [DW-1:0] aluRes_o;
  logic [AW-1:0] rd_o;
  logic [DW-1:0] wbData_o;
  logic [1:0]    occupancy;

  pipe_stage_reg #(.DATA_W(DW), .RA_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .memToReg_i (memToReg_i),
    .regWrite_i (regWrite_i),
    .readData_i (readData_i),
    .aluRes_i   (aluRes_i),
    .rd_i       (rd_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .memToReg_o (memToReg_o),
    .regWrite_o (regWrite_o),
    .readData_o (readData_o),
    .aluRes_o   (aluRes_o),
    .rd_o       (rd_o),
    .wbData_o   (wbData_o),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  // Reference: the block is a 2-deep FIFO whose head is the output beat.
  beat_t model_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    beat_t h;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
    check({tag, ".in_ready"},  32'(in_ready),  32'(model_q.size() < 2));
    check({tag, ".occupancy"}, 32'(occupancy), 32'(model_q.size()));
    if (model_q.size() != 0) begin
      h = model_q[0];
      check({tag, ".memToReg"}, 32'(memToReg_o), 32'(h.m));
      check({tag, ".regWrite"}, 32'(regWrite_o), 32'(h.w));
      check({tag, ".readData"}, 32'(readData_o), 32'(h.rdat));
      check({tag, ".aluRes"},   32'(aluRes_o),   32'(h.alu));
      check({tag, ".rd"},       32'(rd_o),       32'(h.rd));
      check({tag, ".wbData"},   32'(wbData_o),   32'(h.m ? h.rdat : h.alu));
    end else begin
      check({tag, ".regWrite_idle"}, 32'(regWrite_o), 32'd0);
    end
  endtask

  // Called at a negedge: drives inputs, advances one clock, checks at next negedge.
  task automatic step(input string tag, input logic iv, input logic fl,
                      input logic ordy, input beat_t b);
    bit acc, con;
    in_valid  = iv;
    flush     = fl;
    out_ready = ordy;
    {memToReg_i, regWrite_i, readData_i, aluRes_i, rd_i} = b;
    acc = iv && (model_q.size() < 2);
    con = ordy && (model_q.size() != 0);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (con) void'(model_q.pop_front());
      if (acc) model_q.push_back(b);
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b = beat_t'({$urandom, $urandom});
    return b;
  endfunction

  task automatic check_reset_zero(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid),  32'd0);
    check({tag, ".regWrite"},  32'(regWrite_o), 32'd0);
    check({tag, ".memToReg"},  32'(memToReg_o), 32'd0);
    check({tag, ".readData"},  32'(readData_o), 32'd0);
    check({tag, ".aluRes"},    32'(aluRes_o),   32'd0);
    check({tag, ".wbData"},    32'(wbData_o),   32'd0);
    check({tag, ".rd"},        32'(rd_o),       32'd0);
    check({tag, ".occupancy"}, 32'(occupancy),  32'd0);
    check({tag, ".in_ready"},  32'(in_ready),   32'd1);
  endtask

  beat_t b;
  beat_t idle_b;

  initial begin
    idle_b = '0;
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_zero("post_reset");

    // Single beat, 1-cycle latency, then drains
    b = '{m: 1'b1, w: 1'b1, rdat: 8'hA5, alu: 8'h3C, rd: 3'd5};
    step("single", 1'b1, 1'b0, 1'b1, b);
    check("single.wb_const", 32'(wbData_o), 32'hA5);
    check("single.rd_const", 32'(rd_o), 32'd5);
    check("single.rw_const", 32'(regWrite_o), 32'd1);
    step("single_drain", 1'b0, 1'b0, 1'b1, idle_b);
    check("single.gone", 32'(out_valid), 32'd0);

    // Streaming 10 beats with out_ready held high
    for (int i = 0; i < 10; i++) begin
      b = '{m: 1'b0, w: 1'b1, rdat: 8'hFF, alu: 8'(i), rd: 3'(i)};
      step("stream", 1'b1, 1'b0, 1'b1, b);
      check("stream.wb_seq", 32'(wbData_o), 32'(i));
      check("stream.occ1", 32'(occupancy), 32'd1);
    end
    step("stream_drain", 1'b0, 1'b0, 1'b1, idle_b);

    // Backpressure: three beats offered, only two held
    for (int i = 0; i < 3; i++) begin
      b = '{m: 1'b0, w: 1'b0, rdat: 8'h00, alu: 8'h50 + 8'(i), rd: 3'(i)};
      step("bp_fill", 1'b1, 1'b0, 1'b0, b);
    end
    check("bp.occ2", 32'(occupancy), 32'd2);
    check("bp.not_ready", 32'(in_ready), 32'd0);
    check("bp.head", 32'(wbData_o), 32'h50);
    step("bp_drain0", 1'b0, 1'b0, 1'b1, idle_b);
    check("bp.second", 32'(wbData_o), 32'h51);
    check("bp.ready_back", 32'(in_ready), 32'd1);
    step("bp_drain1", 1'b0, 1'b0, 1'b1, idle_b);

    // Flush while full, with a beat offered in the same cycle
    step("fl_fill0", 1'b1, 1'b0, 1'b0, rand_beat());
    step("fl_fill1", 1'b1, 1'b0, 1'b0, rand_beat());
    check("fl.occ2", 32'(occupancy), 32'd2);
    step("flush", 1'b1, 1'b1, 1'b1, rand_beat());
    check("fl.occ0", 32'(occupancy), 32'd0);
    step("fl_after", 1'b0, 1'b0, 1'b1, idle_b);
    check("fl.no_ghost", 32'(out_valid), 32'd0);

    // Asynchronous reset pulse between edges while full
    step("ar_fill0", 1'b1, 1'b0, 1'b0, rand_beat());
    step("ar_fill1", 1'b1, 1'b0, 1'b0, rand_beat());
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 model_q.delete();
    check_reset_zero("async_rst");
    rst = 1'b1;
    @(negedge clk);
    check_outputs("ar_idle");
    b = '{m: 1'b1, w: 1'b1, rdat: 8'h77, alu: 8'h11, rd: 3'd2};
    step("ar_beat", 1'b1, 1'b0, 1'b1, b);
    check("ar.latency1", 32'(wbData_o), 32'h77);
    step("ar_drain", 1'b0, 1'b0, 1'b1, idle_b);

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 2) != 0), rand_beat());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
